// File: rtl/dexmpl_pkg.sv
// Shared definitions for the design-example host controller: FSM encoding and
// the result the standard design example produces at completion.
package dexmpl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] A_DONE  = 4'b1101;
    localparam logic       E_DONE  = 1'b1;
    localparam int         LAT_NOM = 14;

endpackage

// File: rtl/dexmpl_wait_cnt.sv
// Wait-cycle counter with synchronous clear, count enable and a terminal-count flag.
// Counting stops at TIMEOUT, so the value never wraps.
module dexmpl_wait_cnt #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    assign at_limit = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dexmpl_host_ctrl.sv
// Initiator for the A/E/F design example: issues a start pulse, waits for F with a
// cycle budget, then captures A, E, latency and completion status.
module dexmpl_host_ctrl
    import dexmpl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [3:0]       A_i4,
    input  logic             E_i,
    input  logic             F_i,
    output logic             start_o,
    output logic             busy_ro,
    output logic             done_ro,
    output logic [3:0]       a_final_ro4,
    output logic             e_final_ro,
    output logic [CNT_W-1:0] cycles_ro,
    output logic             timeout_ro,
    output logic [7:0]       runs_ro8
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;
    logic             cnt_clr;
    logic             cnt_en;

    assign cnt_clr = (state == IDLE) && req_i;
    assign cnt_en  = (state == WAIT) && !F_i;

    dexmpl_wait_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            start_o     <= 1'b0;
            busy_ro     <= 1'b0;
            done_ro     <= 1'b0;
            a_final_ro4 <= '0;
            e_final_ro  <= 1'b0;
            cycles_ro   <= '0;
            timeout_ro  <= 1'b0;
            runs_ro8    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        state      <= START;
                        start_o    <= 1'b1;
                        busy_ro    <= 1'b1;
                        timeout_ro <= 1'b0;
                    end
                end
                START: begin
                    state   <= WAIT;
                    start_o <= 1'b0;
                end
                WAIT: begin
                    // Completion is checked first so F on the last budgeted cycle still counts.
                    if (F_i || at_limit) begin
                        state       <= DONE;
                        done_ro     <= 1'b1;
                        a_final_ro4 <= A_i4;
                        e_final_ro  <= E_i;
                        cycles_ro   <= cnt;
                        if (F_i) begin
                            runs_ro8 <= runs_ro8 + 8'd1;
                        end else begin
                            timeout_ro <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_ro <= 1'b0;
                    busy_ro <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
